// File: rtl/kf_pkg.sv
// kf_pkg: shared constants, state encoding and instruction layout for the Kalman-filter microcode sequencer
package kf_pkg;
   localparam int ADDRW_D = 5;
   localparam int PCW_D = 6;
   localparam int OPW_D = 3;
   localparam int NITW_D = 8;
   // control-bit offsets above the op field; b sits in the LSBs, then a, then op
   localparam int CTL_WRITE = 0;
   localparam int CTL_RQ = 1;
   localparam int CTL_RD = 2;
   localparam int CTL_MULTI = 3;
   localparam int CTL_LAST = 4;
   localparam int NCTL = 5;
   localparam logic [OPW_D-1:0] OP_ADD = 3'd0;
   localparam logic [OPW_D-1:0] OP_SUB = 3'd1;
   localparam logic [OPW_D-1:0] OP_MUL = 3'd2;
   localparam logic [OPW_D-1:0] OP_DIV = 3'd3;
   localparam logic [OPW_D-1:0] OP_PASS = 3'd4;
   typedef enum logic [2:0] {S_IDLE, S_WAIT_MEAS, S_EXEC, S_STALL, S_FIN} state_t;
   function automatic int instr_width(input int addrw, input int opw);
      return 2*addrw + opw + NCTL;
   endfunction
endpackage

// File: rtl/kf_instr_decode.sv
// kf_instr_decode: instruction field extraction and EXEC/STALL gating of bank and accumulator enables
module kf_instr_decode
   import kf_pkg::*;
#(
   parameter int ADDRW = ADDRW_D,
   parameter int OPW = OPW_D,
   localparam int IW = instr_width(ADDRW, OPW)
) (
   input  logic [IW-1:0]    instr,
   input  logic [IW-1:0]    held,
   input  logic             in_exec,
   input  logic             in_stall,
   input  logic             alu_done,
   output logic             commit,
   output logic             last,
   output logic             alu_start,
   output logic             write,
   output logic             rq_we,
   output logic             rd_we,
   output logic [ADDRW-1:0] dira,
   output logic [ADDRW-1:0] dirb,
   output logic [OPW-1:0]   alu_op
);
   localparam int CB = 2*ADDRW + OPW;
   logic [IW-1:0] cur;
   logic active;
   always_comb begin
      cur = in_stall ? held : instr;
      active = in_exec | in_stall;
      // a stalled instruction commits only when the ALU reports completion
      commit = in_exec ? !cur[CB+CTL_MULTI] : in_stall & alu_done;
      last = cur[CB+CTL_LAST];
      alu_start = in_exec & cur[CB+CTL_MULTI];
      write = commit & cur[CB+CTL_WRITE];
      rq_we = commit & cur[CB+CTL_RQ];
      rd_we = commit & cur[CB+CTL_RD];
      dira = active ? cur[ADDRW +: ADDRW] : '0;
      dirb = active ? cur[0 +: ADDRW] : '0;
      alu_op = active ? cur[2*ADDRW +: OPW] : '0;
   end
endmodule

// File: rtl/kf_sequencer.sv
// kf_sequencer: microcode sequencer fetching the program ROM and driving the Kalman-filter datapath
module kf_sequencer
   import kf_pkg::*;
#(
   parameter int ADDRW = ADDRW_D,
   parameter int PCW = PCW_D,
   parameter int OPW = OPW_D,
   parameter int NITW = NITW_D,
   localparam int IW = instr_width(ADDRW, OPW)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NITW-1:0]  n_iter,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic             meas_valid,
   output logic             meas_ack,
   output logic [PCW-1:0]   pc,
   input  logic [IW-1:0]    instr,
   output logic [OPW-1:0]   alu_op,
   output logic             alu_start,
   input  logic             alu_done,
   output logic             write,
   output logic [ADDRW-1:0] dira,
   output logic [ADDRW-1:0] dirb,
   output logic             rq_we,
   output logic             rd_we,
   output logic [NITW-1:0]  iter_cnt
);
   state_t state, nxt;
   logic [NITW-1:0] n_reg, iter_inc;
   logic [IW-1:0] held;
   logic commit, last, accept, pc_end;
   kf_instr_decode #(.ADDRW(ADDRW), .OPW(OPW)) u_dec (
      .instr(instr),
      .held(held),
      .in_exec(state == S_EXEC),
      .in_stall(state == S_STALL),
      .alu_done(alu_done),
      .commit(commit),
      .last(last),
      .alu_start(alu_start),
      .write(write),
      .rq_we(rq_we),
      .rd_we(rd_we),
      .dira(dira),
      .dirb(dirb),
      .alu_op(alu_op)
   );
   always_comb begin
      accept = state == S_IDLE && start;
      iter_inc = iter_cnt + 1'b1;
      pc_end = &pc;
      busy = state inside {S_WAIT_MEAS, S_EXEC, S_STALL};
      done = state == S_FIN;
      meas_ack = state == S_WAIT_MEAS && meas_valid;
      nxt = state;
      if (accept) nxt = n_iter == '0 ? S_FIN : S_WAIT_MEAS;
      if (meas_ack) nxt = S_EXEC;
      if (alu_start) nxt = S_STALL;
      if (commit) nxt = last ? (iter_inc == n_reg ? S_FIN : S_WAIT_MEAS) : (pc_end ? S_FIN : S_EXEC);
      if (done) nxt = S_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         pc <= '0;
         iter_cnt <= '0;
         n_reg <= '0;
         err <= 1'b0;
         held <= '0;
      end else begin
         state <= nxt;
         if (accept) begin
            n_reg <= n_iter;
            iter_cnt <= '0;
            err <= 1'b0;
         end
         if (meas_ack) pc <= '0;
         if (alu_start) held <= instr;
         if (commit && last) iter_cnt <= iter_inc;
         // running off the end of the ROM aborts the run instead of wrapping
         if (commit && !last && pc_end) err <= 1'b1;
         if (commit && !last && !pc_end) pc <= pc + 1'b1;
      end
   end
endmodule

// File: tb/tb_kf_sequencer.sv
// tb_kf_sequencer: directed and randomized checks of kf_sequencer against a behavioural model
module tb_kf_sequencer;
   logic clk = 0, rst = 1, start = 0, meas_valid = 0, alu_done = 0;
   logic [7:0] n_iter = 0;
   logic busy, done, err, meas_ack, alu_start, write, rq_we, rd_we;
   logic [5:0] pc;
   logic [17:0] instr;
   logic [2:0] alu_op;
   logic [4:0] dira, dirb;
   logic [7:0] iter_cnt;
   logic [17:0] rom [64];
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   assign instr = rom[pc];
   kf_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .n_iter(n_iter), .busy(busy), .done(done), .err(err),
      .meas_valid(meas_valid), .meas_ack(meas_ack), .pc(pc), .instr(instr), .alu_op(alu_op),
      .alu_start(alu_start), .alu_done(alu_done), .write(write), .dira(dira), .dirb(dirb),
      .rq_we(rq_we), .rd_we(rd_we), .iter_cnt(iter_cnt)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [17:0] mk(input bit l, input bit m, input bit rd, input bit rq, input bit w,
                                      input logic [2:0] op, input logic [4:0] a, input logic [4:0] b);
      return {l, m, rd, rq, w, op, a, b};
   endfunction
   // model: ph 0 idle, 1 awaiting measurement, 2 running, 3 waiting on ALU, 4 finishing
   int ph = 0, m_pc = 0, m_it = 0, m_n = 0;
   bit m_err = 0, armed = 0, fresh = 0;
   logic [17:0] m_hold = '0, cur_m;
   logic cm, mul;
   always @(negedge clk) begin
      cur_m = ph == 3 ? m_hold : rom[m_pc];
      mul = cur_m[16];
      cm = (ph == 2 && !mul) || (ph == 3 && alu_done);
      if (armed) begin
         chk("busy", busy, ph >= 1 && ph <= 3);
         chk("done", done, ph == 4);
         chk("meas_ack", meas_ack, ph == 1 && meas_valid);
         chk("alu_start", alu_start, ph == 2 && mul);
         chk("write", write, cm & cur_m[13]);
         chk("rq_we", rq_we, cm & cur_m[14]);
         chk("rd_we", rd_we, cm & cur_m[15]);
         chk("pc", pc, m_pc);
         chk("iter_cnt", iter_cnt, m_it);
         chk("err", err, m_err);
         if (ph == 2 || ph == 3) begin
            chk("dira", dira, cur_m[9:5]);
            chk("dirb", dirb, cur_m[4:0]);
            chk("alu_op", alu_op, cur_m[12:10]);
         end
         if (fresh) chk("reset_addr", {alu_op, dira, dirb}, 0);
      end
      if (rst) begin
         ph = 0; m_pc = 0; m_it = 0; m_err = 0; fresh = 1; armed = 1;
      end else begin
         fresh = 0;
         if (ph == 0) begin
            if (start) begin
               m_n = n_iter; m_it = 0; m_err = 0; ph = n_iter == 0 ? 4 : 1;
            end
         end else if (ph == 1) begin
            if (meas_valid) begin m_pc = 0; ph = 2; end
         end else if (ph == 4) ph = 0;
         else if (ph == 2 && mul) begin m_hold = cur_m; ph = 3; end
         else if (cm) begin
            if (cur_m[17]) begin m_it++; ph = m_it == m_n ? 4 : 1; end
            else if (m_pc == 63) begin m_err = 1; ph = 4; end
            else begin m_pc++; ph = 2; end
         end
      end
   end
   task automatic cyc();
      @(posedge clk); #1;
   endtask
   task automatic mid();
      @(negedge clk); #1;
   endtask
   task automatic rand_rom();
      int len;
      bit ovf;
      len = $urandom_range(1, 8);
      ovf = $urandom_range(0, 5) == 0;
      for (int i = 0; i < 64; i++) begin
         rom[i] = 18'($urandom) & 18'h0FFFF;
         rom[i][16] = $urandom_range(0, 3) == 0;
         rom[i][17] = !ovf && (i == len - 1 || $urandom_range(0, 9) == 0);
      end
   endtask
   initial begin
      int acks, dones, w;
      bit got;
      for (int i = 0; i < 64; i++) rom[i] = '0;
      cyc(); cyc(); rst = 0;
      mid();
      chk("rst_busy", busy, 0); chk("rst_pc", pc, 0); chk("rst_iter", iter_cnt, 0); chk("rst_err", err, 0);
      // single iteration: plain write then last with rq_we
      rom[0] = mk(0, 0, 0, 0, 1, 3'd0, 5'd3, 5'd2);
      rom[1] = mk(1, 0, 0, 1, 0, 3'd0, 5'd0, 5'd0);
      cyc(); start = 1; n_iter = 1; meas_valid = 1;
      cyc(); start = 0; mid(); chk("s1_busy", busy, 1); chk("s1_ack", meas_ack, 1);
      cyc(); mid(); chk("s1_write", write, 1); chk("s1_dira", dira, 3); chk("s1_dirb", dirb, 2); chk("s1_ack_once", meas_ack, 0);
      cyc(); mid(); chk("s1_rq", rq_we, 1); chk("s1_wr_off", write, 0);
      cyc(); mid(); chk("s1_done", done, 1); chk("s1_busy_off", busy, 0); chk("s1_iter", iter_cnt, 1);
      cyc(); meas_valid = 0; mid(); chk("s1_done_pulse", done, 0);
      // zero iterations: straight to done without fetching
      cyc(); start = 1; n_iter = 0; mid(); chk("s2_busy0", busy, 0);
      cyc(); start = 0; mid(); chk("s2_done", done, 1); chk("s2_busy", busy, 0); chk("s2_pc", pc, 1); chk("s2_write", write, 0);
      cyc(); mid(); chk("s2_done_off", done, 0);
      // multi-cycle op with alu_done four cycles after alu_start
      rom[0] = mk(0, 1, 0, 0, 1, 3'd2, 5'd7, 5'd1);
      rom[1] = mk(1, 0, 0, 0, 0, 3'd4, 5'd0, 5'd0);
      cyc(); start = 1; n_iter = 1; meas_valid = 1;
      cyc(); start = 0;
      cyc(); alu_done = 1; mid(); chk("s3_start", alu_start, 1); chk("s3_wr0", write, 0); chk("s3_dira", dira, 7);
      for (int i = 0; i < 3; i++) begin
         cyc(); alu_done = 0; mid(); chk("s3_stall_wr", write, 0); chk("s3_stall_dira", dira, 7); chk("s3_stall_start", alu_start, 0);
      end
      cyc(); alu_done = 1; mid(); chk("s3_commit_wr", write, 1); chk("s3_commit_dira", dira, 7); chk("s3_op", alu_op, 2);
      cyc(); alu_done = 0; mid(); chk("s3_pc", pc, 1); chk("s3_op2", alu_op, 4);
      cyc(); mid(); chk("s3_done", done, 1);
      cyc(); meas_valid = 0;
      // three iterations with slow measurements
      rom[0] = mk(0, 0, 0, 0, 1, 3'd1, 5'd1, 5'd0);
      rom[1] = mk(1, 0, 1, 0, 0, 3'd0, 5'd0, 5'd0);
      cyc(); start = 1; n_iter = 3;
      cyc(); start = 0;
      acks = 0; dones = 0; w = 0;
      for (int k = 0; k < 200 && dones == 0; k++) begin
         meas_valid = w >= 5;
         mid();
         if (meas_ack) begin acks++; w = 0; end else w++;
         if (done) dones++;
         cyc();
      end
      meas_valid = 0;
      chk("s4_acks", acks, 3); chk("s4_dones", dones, 1); chk("s4_iter", iter_cnt, 3);
      // program without last runs off the ROM end
      for (int i = 0; i < 64; i++) rom[i] = 18'($urandom) & 18'h0FFFF;
      cyc(); start = 1; n_iter = 1; meas_valid = 1;
      cyc(); start = 0;
      got = 0;
      for (int k = 0; k < 150 && !got; k++) begin
         mid();
         if (done) begin got = 1; chk("s5_err", err, 1); chk("s5_pc", pc, 63); end
         cyc();
      end
      chk("s5_done_seen", got, 1);
      meas_valid = 0; start = 1; n_iter = 0;
      cyc(); start = 0; mid(); chk("s5_err_clr", err, 0);
      // reset while stalled
      rom[0] = mk(0, 1, 0, 0, 1, 3'd1, 5'd9, 5'd4);
      rom[1] = mk(1, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0);
      cyc(); cyc(); start = 1; n_iter = 1; meas_valid = 1; alu_done = 0;
      cyc(); start = 0;
      cyc(); mid(); chk("s6_start", alu_start, 1);
      cyc(); rst = 1; mid(); chk("s6_stall_busy", busy, 1);
      cyc(); rst = 0; meas_valid = 0; mid();
      chk("s6_busy", busy, 0); chk("s6_done", done, 0); chk("s6_pc", pc, 0); chk("s6_dira", dira, 0); chk("s6_iter", iter_cnt, 0);
      for (int k = 0; k < 4000; k++) begin
         cyc();
         if (k % 600 == 0) rand_rom();
         start = $urandom_range(0, 7) == 0;
         n_iter = 8'($urandom_range(0, 3));
         meas_valid = $urandom_range(0, 1) == 1;
         alu_done = $urandom_range(0, 2) == 0;
         rst = $urandom_range(0, 299) == 0;
      end
      cyc(); rst = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
